// File: rtl/mux_mult_pkg.sv
// Shared types and sizing helpers for the iterative mux-based multiplier.
package mux_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Number of CALC steps needed to retire every multiplier bit.
    function automatic int nSteps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Step counter width; a single-step configuration still gets one bit.
    function automatic int cntWidth(input int width, input int bpc);
        int n;
        n = nSteps(width, bpc);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_pp_row.sv
// One accumulation step: BPC rows of mux-selected partial products, each row
// added into the running sum by a ripple chain of full-adder cells.
module mux_pp_row
    import mux_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic [WIDTH-1:0]     x_reg_i,
    input  logic [BPC-1:0]       y_bits_i,
    input  logic [WIDTH-1:0]     acc_slice_i,
    output logic [WIDTH+BPC-1:0] sum_o
);

    localparam int SW = WIDTH + BPC;

    // rows[0] is the incoming accumulator slice; rows[k+1] has retired bit k.
    logic [SW-1:0] rows [BPC+1];

    assign rows[0] = {{BPC{1'b0}}, acc_slice_i};

    for (genvar k = 0; k < BPC; k++) begin : g_row
        logic [SW-1:0] pp;
        logic [SW-1:0] s;
        logic [SW-1:0] carry;

        // Multiplier bit k selects the multiplicand (weighted by k) or zero.
        assign pp       = y_bits_i[k] ? (SW'(x_reg_i) << k) : '0;
        assign carry[0] = 1'b0;

        for (genvar b = 0; b < SW; b++) begin : g_fa
            assign s[b] = rows[k][b] ^ pp[b] ^ carry[b];
            if (b < SW - 1) begin : g_carry
                assign carry[b+1] = (rows[k][b] & pp[b]) | (carry[b] & (rows[k][b] ^ pp[b]));
            end
        end

        assign rows[k+1] = s;
    end

    assign sum_o = rows[BPC];

endmodule

// File: rtl/mux_mult_iter.sv
// Iterative signed/unsigned multiplier with valid/ready handshakes.
// Works on operand magnitudes, retires BPC multiplier bits per CALC cycle and
// applies the sign once in FIX. The accumulator shifts right BPC bits per
// step so the partial-product row always adds into a fixed upper slice; after
// all steps the full 2*WIDTH product sits in the accumulator.
// Legal configurations: WIDTH 4..32, BPC in {1,2,4} dividing WIDTH.
module mux_mult_iter
    import mux_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int            N_STEPS = nSteps(WIDTH, BPC);
    localparam int            CW      = cntWidth(WIDTH, BPC);
    localparam logic [CW-1:0] LAST    = CW'(N_STEPS - 1);

    state_t               state_q;
    logic [WIDTH-1:0]     x_q;
    logic [WIDTH-1:0]     y_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 sign_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]       xMag;
    logic [WIDTH-1:0]       yMag;
    logic [WIDTH+BPC-1:0]   rowSum;
    logic [2*WIDTH+BPC-1:0] accWide;
    logic [2*WIDTH-1:0]     acc_d;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        xMag = x;
        yMag = y;
        if (is_signed && x[WIDTH-1]) xMag = -x;
        if (is_signed && y[WIDTH-1]) yMag = -y;
    end

    mux_pp_row #(
        .WIDTH(WIDTH),
        .BPC  (BPC)
    ) u_row (
        .x_reg_i    (x_q),
        .y_bits_i   (y_q[BPC-1:0]),
        .acc_slice_i(acc_q[2*WIDTH-1:WIDTH]),
        .sum_o      (rowSum)
    );

    // New upper slice joins the untouched lower half, then everything shifts down.
    always_comb begin
        accWide = {rowSum, acc_q[WIDTH-1:0]};
        acc_d   = accWide[2*WIDTH+BPC-1:BPC];
    end

    // Control FSM and datapath registers; outputs are registered here too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= xMag;
                        y_q     <= yMag;
                        sign_q  <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    y_q   <= y_q >> BPC;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q   <= sign_q ? -acc_q : acc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_mux_mult_iter.sv
// Self-checking bench for mux_mult_iter: one 8-bit/1-bit-per-cycle instance
// and one 16-bit/4-bits-per-cycle instance, scoreboard queues per instance.
module tb_mux_mult_iter;

    logic clk;
    logic reset;

    logic        aInValid, aInReady, aSigned, aOutValid, aOutReady, aBusy;
    logic [7:0]  aX, aY;
    logic [15:0] aProduct;

    logic        bInValid, bInReady, bSigned, bOutValid, bOutReady, bBusy;
    logic [15:0] bX, bY;
    logic [31:0] bProduct;

    int vecCount  = 0;
    int missCount = 0;

    logic [63:0] expQA[$];
    logic [63:0] expQB[$];

    mux_mult_iter #(.WIDTH(8), .BPC(1)) dutA (
        .clk(clk), .reset(reset), .in_valid(aInValid), .in_ready(aInReady),
        .x(aX), .y(aY), .is_signed(aSigned), .out_valid(aOutValid),
        .out_ready(aOutReady), .product(aProduct), .busy(aBusy)
    );

    mux_mult_iter #(.WIDTH(16), .BPC(4)) dutB (
        .clk(clk), .reset(reset), .in_valid(bInValid), .in_ready(bInReady),
        .x(bX), .y(bY), .is_signed(bSigned), .out_valid(bOutValid),
        .out_ready(bOutReady), .product(bProduct), .busy(bBusy)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product computed with wide signed integer arithmetic.
    function automatic logic [63:0] refMul(input logic [31:0] xv, input logic [31:0] yv,
                                           input bit sgn, input int w);
        longint a, b, p;
        logic [63:0] mask;
        a = longint'({32'b0, xv});
        b = longint'({32'b0, yv});
        if (sgn && xv[w-1]) a = a - (longint'(1) << w);
        if (sgn && yv[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic startA(input logic [7:0] xv, input logic [7:0] yv, input bit s, input logic [63:0] e);
        @(negedge clk);
        aX = xv; aY = yv; aSigned = s; aInValid = 1'b1;
        expQA.push_back(e);
        @(negedge clk);
        aInValid = 1'b0;
    endtask

    task automatic startB(input logic [15:0] xv, input logic [15:0] yv, input bit s, input logic [63:0] e);
        @(negedge clk);
        bX = xv; bY = yv; bSigned = s; bInValid = 1'b1;
        expQB.push_back(e);
        @(negedge clk);
        bInValid = 1'b0;
    endtask

    task automatic waitA(output int cycles, output bit readyLow, output bit timedOut);
        cycles = 0; readyLow = 1'b1;
        while (aOutValid !== 1'b1 && cycles < 40) begin
            if (aInReady !== 1'b0) readyLow = 1'b0;
            @(negedge clk);
            cycles++;
        end
        timedOut = (aOutValid !== 1'b1);
    endtask

    task automatic waitB(output int cycles, output bit timedOut);
        cycles = 0;
        while (bOutValid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        timedOut = (bOutValid !== 1'b1);
    endtask

    task automatic consumeA;
        aOutReady = 1'b1;
        @(negedge clk);
        aOutReady = 1'b0;
    endtask

    task automatic consumeB;
        bOutReady = 1'b1;
        @(negedge clk);
        bOutReady = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        vecCount++; if (aInReady !== 1'b1) begin missCount++; $display("[TB] FAIL reset_a_in_ready got %b want 1", aInReady); end
        vecCount++; if (aOutValid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_a_out_valid got %b want 0", aOutValid); end
        vecCount++; if (aBusy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_a_busy got %b want 0", aBusy); end
        vecCount++; if (aProduct !== 16'h0) begin missCount++; $display("[TB] FAIL reset_a_product got %h want 0000", aProduct); end
        vecCount++; if (bInReady !== 1'b1 || bOutValid !== 1'b0 || bProduct !== 32'h0) begin
            missCount++; $display("[TB] FAIL reset_b got rdy=%b vld=%b prod=%h want 1/0/0", bInReady, bOutValid, bProduct);
        end
    endtask

    task automatic test_unsigned;
        int cyc; bit rl, to; logic [63:0] e;
        startA(8'd200, 8'd150, 1'b0, 64'd30000);
        vecCount++; if (aBusy !== 1'b1) begin missCount++; $display("[TB] FAIL unsigned_busy got %b want 1", aBusy); end
        waitA(cyc, rl, to);
        vecCount++; if (to) begin missCount++; $display("[TB] FAIL unsigned_timeout got no out_valid want out_valid"); end
        vecCount++; if (cyc != 9) begin missCount++; $display("[TB] FAIL unsigned_latency got %0d want 9", cyc); end
        vecCount++; if (!rl) begin missCount++; $display("[TB] FAIL unsigned_in_ready got 1 during op want 0"); end
        e = expQA.pop_front();
        vecCount++; if (aProduct !== e[15:0]) begin missCount++; $display("[TB] FAIL unsigned_product got %h want %h", aProduct, e[15:0]); end
        consumeA;
    endtask

    task automatic test_signed;
        logic [7:0]  xs [3] = '{8'h80, 8'hF9, 8'h7F};
        logic [7:0]  ys [3] = '{8'h80, 8'h05, 8'hFF};
        logic [15:0] ps [3] = '{16'h4000, 16'hFFDD, 16'hFF81};
        int cyc; bit rl, to; logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            startA(xs[i], ys[i], 1'b1, {48'b0, ps[i]});
            waitA(cyc, rl, to);
            e = expQA.pop_front();
            vecCount++;
            if (to || aProduct !== e[15:0]) begin
                missCount++; $display("[TB] FAIL signed_%0d got %h (timeout=%0b) want %h", i, aProduct, to, e[15:0]);
            end
            consumeA;
        end
    endtask

    task automatic test_backpressure;
        int cyc; bit rl, to; logic [63:0] e;
        startA(8'd13, 8'd11, 1'b0, 64'd143);
        waitA(cyc, rl, to);
        vecCount++; if (to) begin missCount++; $display("[TB] FAIL bp_timeout got no out_valid want out_valid"); end
        for (int i = 0; i < 5; i++) begin
            aOutReady = 1'b0;
            aInValid  = i[0];
            aX = 8'($urandom); aY = 8'($urandom); aSigned = 1'($urandom);
            @(negedge clk);
            vecCount++;
            if (aOutValid !== 1'b1 || aProduct !== 16'd143 || aInReady !== 1'b0) begin
                missCount++; $display("[TB] FAIL bp_hold_%0d got vld=%b prod=%h rdy=%b want 1/008f/0", i, aOutValid, aProduct, aInReady);
            end
        end
        aInValid = 1'b0;
        e = expQA.pop_front();
        vecCount++; if (aProduct !== e[15:0]) begin missCount++; $display("[TB] FAIL bp_product got %h want %h", aProduct, e[15:0]); end
        consumeA;
        vecCount++;
        if (aOutValid !== 1'b0 || aInReady !== 1'b1 || aProduct !== 16'd143) begin
            missCount++; $display("[TB] FAIL bp_release got vld=%b rdy=%b prod=%h want 0/1/008f", aOutValid, aInReady, aProduct);
        end
        @(negedge clk);
        vecCount++; if (aBusy !== 1'b0) begin missCount++; $display("[TB] FAIL bp_no_accept got busy=%b want 0", aBusy); end
    endtask

    task automatic test_reset_mid;
        int cyc; bit rl, to; logic [63:0] e;
        startA(8'h55, 8'h66, 1'b0, refMul(32'h55, 32'h66, 1'b0, 8));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expQA.delete();
        vecCount++;
        if (aInReady !== 1'b1 || aOutValid !== 1'b0 || aProduct !== 16'h0 || aBusy !== 1'b0) begin
            missCount++; $display("[TB] FAIL midreset got rdy=%b vld=%b prod=%h busy=%b want 1/0/0000/0", aInReady, aOutValid, aProduct, aBusy);
        end
        startA(8'd3, 8'd4, 1'b0, 64'd12);
        waitA(cyc, rl, to);
        e = expQA.pop_front();
        vecCount++; if (to || cyc != 9) begin missCount++; $display("[TB] FAIL midreset_latency got %0d want 9", cyc); end
        vecCount++; if (aProduct !== e[15:0]) begin missCount++; $display("[TB] FAIL midreset_product got %h want %h", aProduct, e[15:0]); end
        consumeA;
    endtask

    task automatic test_wide;
        logic [15:0] xs [3] = '{16'hFFFF, 16'h8000, 16'h0000};
        logic [15:0] ys [3] = '{16'hFFFF, 16'h8000, 16'h1234};
        bit          ss [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] ps [3] = '{32'hFFFE0001, 32'h40000000, 32'h0};
        int cyc; bit to; logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            startB(xs[i], ys[i], ss[i], {32'b0, ps[i]});
            waitB(cyc, to);
            e = expQB.pop_front();
            vecCount++; if (to || cyc != 5) begin missCount++; $display("[TB] FAIL wide_latency_%0d got %0d want 5", i, cyc); end
            vecCount++; if (bProduct !== e[31:0]) begin missCount++; $display("[TB] FAIL wide_product_%0d got %h want %h", i, bProduct, e[31:0]); end
            consumeB;
        end
    endtask

    task automatic test_random;
        int accepted, produced, cyc;
        logic [63:0] e;
        logic [7:0] pickA [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        logic [15:0] pickB [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
        accepted = 0; produced = 0; cyc = 0;
        while ((accepted < 300 || expQA.size() != 0) && cyc < 20000) begin
            @(negedge clk); cyc++;
            aOutReady = 1'($urandom_range(0, 1));
            if (aOutValid === 1'b1 && aOutReady) begin
                vecCount++;
                if (expQA.size() == 0) begin
                    missCount++; $display("[TB] FAIL rand_a_spurious got product %h want none", aProduct);
                end else begin
                    e = expQA.pop_front();
                    if (aProduct !== e[15:0]) begin missCount++; $display("[TB] FAIL rand_a_product got %h want %h", aProduct, e[15:0]); end
                end
                produced++;
            end
            if (accepted < 300) begin
                aInValid = ($urandom_range(0, 3) != 0);
                aX = ($urandom_range(0, 3) == 0) ? pickA[$urandom_range(0, 3)] : 8'($urandom);
                aY = ($urandom_range(0, 3) == 0) ? pickA[$urandom_range(0, 3)] : 8'($urandom);
                aSigned = 1'($urandom_range(0, 1));
            end else begin
                aInValid = 1'b0;
            end
            if (aInValid && aInReady === 1'b1) begin
                expQA.push_back(refMul({24'b0, aX}, {24'b0, aY}, aSigned, 8));
                accepted++;
            end
        end
        aInValid = 1'b0; aOutReady = 1'b0;
        vecCount++; if (produced != accepted || cyc >= 20000) begin missCount++; $display("[TB] FAIL rand_a_count got %0d want %0d", produced, accepted); end

        accepted = 0; produced = 0; cyc = 0;
        while ((accepted < 300 || expQB.size() != 0) && cyc < 20000) begin
            @(negedge clk); cyc++;
            bOutReady = 1'($urandom_range(0, 1));
            if (bOutValid === 1'b1 && bOutReady) begin
                vecCount++;
                if (expQB.size() == 0) begin
                    missCount++; $display("[TB] FAIL rand_b_spurious got product %h want none", bProduct);
                end else begin
                    e = expQB.pop_front();
                    if (bProduct !== e[31:0]) begin missCount++; $display("[TB] FAIL rand_b_product got %h want %h", bProduct, e[31:0]); end
                end
                produced++;
            end
            if (accepted < 300) begin
                bInValid = ($urandom_range(0, 3) != 0);
                bX = ($urandom_range(0, 3) == 0) ? pickB[$urandom_range(0, 3)] : 16'($urandom);
                bY = ($urandom_range(0, 3) == 0) ? pickB[$urandom_range(0, 3)] : 16'($urandom);
                bSigned = 1'($urandom_range(0, 1));
            end else begin
                bInValid = 1'b0;
            end
            if (bInValid && bInReady === 1'b1) begin
                expQB.push_back(refMul({16'b0, bX}, {16'b0, bY}, bSigned, 16));
                accepted++;
            end
        end
        bInValid = 1'b0; bOutReady = 1'b0;
        vecCount++; if (produced != accepted || cyc >= 20000) begin missCount++; $display("[TB] FAIL rand_b_count got %0d want %0d", produced, accepted); end
    endtask

    // Test sequence.
    initial begin
        reset = 1'b1;
        aInValid = 1'b0; aOutReady = 1'b0; aX = '0; aY = '0; aSigned = 1'b0;
        bInValid = 1'b0; bOutReady = 1'b0; bX = '0; bY = '0; bSigned = 1'b0;
        @(negedge clk);
        $display("[TB] starting mux_mult_iter checks");
        test_reset;
        test_unsigned;
        test_signed;
        test_backpressure;
        test_reset_mid;
        test_wide;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/mux_mult_iter.md
Name: mux_mult_iter

Overview:
- Parametrised iterative multiplier built on the mux-based partial-product scheme of the existing combinational multiplier cells.
- Each cycle, multiplier bits select (mux) the multiplicand or zero, and a carry-save/ripple row accumulates the result. BPC bits are retired per cycle.
- Adds what the combinational array lacks: valid/ready handshakes, signed/unsigned mode, width and throughput generics, and sequential accumulation.
- Sits between operand sources and the datapath wherever area matters more than single-cycle latency.

Parameters:
- WIDTH, 8, operand width in bits; legal values 4..32.
- BPC, 1, multiplier bits retired per cycle; must divide WIDTH; legal values 1, 2, 4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands; 0 = unsigned. Sampled with operands.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  result.
- busy  out  1  high in CALC or FIX.

Behaviour:
- Reset (sync, active-high):
  - State = IDLE; in_ready = 1; out_valid = 0; busy = 0; product = 0; internal accumulator, counter and sign flag = 0.
- Reset mid-operation: aborts the current operation; nothing is emitted.
- FSM states:
  - IDLE → CALC on in_valid && in_ready.
  - CALC → FIX after N = WIDTH/BPC CALC cycles.
  - FIX → DONE.
  - DONE → IDLE on out_ready.
- in_ready = (state == IDLE), combinational from state only; no dependence on in_valid.
- Accept edge:
  - If is_signed, latch magnitudes |x| and |y| and sign = x[MSB] ^ y[MSB]; otherwise latch raw operands and sign = 0.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as a WIDTH-bit unsigned value; no overflow.
  - Clear the accumulator; counter = 0.
- Each CALC edge:
  - For k = 0..BPC-1: pp_k = y_reg[k] ? (x_reg << k) : 0 (mux select).
  - acc = acc + (sum(pp_k) << (counter*BPC)).
  - y_reg >>= BPC; counter++.
  - Accumulator is 2*WIDTH bits; no truncation is possible.
- FIX edge:
  - product = sign ? -acc : acc (2*WIDTH-bit two's complement).
  - out_valid set to 1.
- Latency: out_valid is high N+1 edges after the accepting edge (WIDTH=8, BPC=1 gives 9; BPC=4 gives 3).
- DONE:
  - product and out_valid are held stable while out_ready = 0.
  - On the edge with out_ready = 1: out_valid → 0, state → IDLE. product retains its value until the next FIX.
- Throughput: one result per N+3 cycles. A new accept is not possible in the handshake cycle of DONE (one-cycle bubble, by design).
- Operand changes: in_valid and operands are ignored outside IDLE. Changes to x, y or is_signed after the accept do not affect the result.
- out_ready asserted outside DONE: no effect.
- Zero operand: full N CALC cycles still run; there is no early termination, so latency is fixed.

Decomposition:
- Package mux_mult_pkg:
  - State enum {IDLE, CALC, FIX, DONE}.
  - Function clog2-based counter width for WIDTH/BPC.
  - Localparam N_STEPS computation helper.
- Sub-module mux_pp_row:
  - Combinational, parameters WIDTH and BPC.
  - Inputs x_reg, BPC multiplier bits and acc slice; output is the updated partial sum.
  - Built as BPC rows of AND/mux-plus-full-adder cells, one row per retired bit.
  - Instantiated once in the CALC datapath.

Test Plan:
- WIDTH=8, BPC=1, unsigned: x=200, y=150 → product=30000 (0x7530); out_valid exactly 9 cycles after accept; in_ready=0 throughout.
- WIDTH=8, signed: x=-128, y=-128 → 16384 (0x4000); x=-7, y=5 → -35 (0xFFDD); x=127, y=-1 → 0xFF81.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → product and out_valid stable. Toggle x/y/in_valid meanwhile → no new accept and no change.
- Reset mid-CALC: assert reset at cycle 4 of an operation → next cycle in_ready=1, out_valid=0, product=0. A following x=3, y=4 gives 12 with normal latency.
- BPC=4, WIDTH=16, unsigned: x=0xFFFF, y=0xFFFF → 0xFFFE0001; out_valid 5 cycles after accept.
- Random regression: 10k operations per (WIDTH, BPC, is_signed) against a reference model with random in_valid/out_ready. Also check that exactly one output is produced per accepted input.
